// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with variable-latency data SRAM loads, sub-word extraction and a load-use aware ID bus.
// Optional feature: define MEM_SUBWORD_LOAD_EN for B/BU/H/HU extraction; otherwise loads return the raw word.
module mem_stage_lsu #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
) (
    input  logic                               clk,
    input  logic                               resetn,
    output logic                               mem_allowin,
    input  logic                               exe_to_mem_valid,
    input  logic [REG_ADDR_W+XLEN+PC_W+5-1:0]  exe_to_mem_bus,
    input  logic                               wb_allowin,
    output logic                               mem_to_wb_valid,
    output logic [1+REG_ADDR_W+XLEN+PC_W-1:0]  mem_to_wb_bus,
    output logic [3+REG_ADDR_W+XLEN-1:0]       mem_to_id_bus,
    input  logic                               data_sram_data_ok,
    input  logic [XLEN-1:0]                    data_sram_rdata
);

    localparam int BUS_W = REG_ADDR_W + XLEN + PC_W + 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               memValid_q;
    logic [BUS_W-1:0]   payload_q;
    logic [XLEN-1:0]    hold_q;

    logic                  regW;
    logic [REG_ADDR_W-1:0] regWAddr;
    logic                  resFromMem;
    logic [2:0]            loadOp;
    logic [XLEN-1:0]       aluResult;
    logic [PC_W-1:0]       pc;
    logic                  newIsLoad;

    assign regW       = payload_q[BUS_W-1];
    assign regWAddr   = payload_q[BUS_W-2 -: REG_ADDR_W];
    assign resFromMem = payload_q[XLEN+PC_W+3];
    assign loadOp     = payload_q[XLEN+PC_W +: 3];
    assign aluResult  = payload_q[PC_W +: XLEN];
    assign pc         = payload_q[PC_W-1:0];
    assign newIsLoad  = exe_to_mem_bus[XLEN+PC_W+3];

    // data_ok only completes a load while in WAIT; elsewhere it is a stray pulse and ignored
    logic waitDataOk;
    logic holdValid;
    logic readyGo;
    logic acceptLoad;

    assign waitDataOk      = (state_q == WAIT) & data_sram_data_ok;
    assign holdValid       = (state_q == HOLD);
    assign readyGo         = ~resFromMem | waitDataOk | holdValid;
    assign mem_allowin     = ~memValid_q | (readyGo & wb_allowin);
    assign mem_to_wb_valid = memValid_q & readyGo;
    assign acceptLoad      = mem_allowin & exe_to_mem_valid & newIsLoad;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acceptLoad) state_d = WAIT;
            end
            WAIT: begin
                if (data_sram_data_ok) begin
                    if (wb_allowin) state_d = acceptLoad ? WAIT : IDLE;
                    else            state_d = HOLD;
                end
            end
            HOLD: begin
                if (wb_allowin) state_d = acceptLoad ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            memValid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_allowin) memValid_q <= exe_to_mem_valid;
        end
    end

    // rdata is only valid with data_ok, so a stalled response must be copied here
    always_ff @(posedge clk) begin
        if (mem_allowin & exe_to_mem_valid) payload_q <= exe_to_mem_bus;
        if (waitDataOk & ~wb_allowin)       hold_q    <= data_sram_rdata;
    end

    logic [XLEN-1:0] rawWord;
    logic [XLEN-1:0] extracted;

    assign rawWord = holdValid ? hold_q : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    localparam int LSB_W = $clog2(XLEN/8);

    logic [LSB_W-1:0] lane;
    logic [LSB_W-1:0] wordLane;
    logic [XLEN-1:0]  rawB, rawH, rawW;

    assign lane     = aluResult[LSB_W-1:0];
    assign wordLane = lane & ~LSB_W'(3);
    assign rawB     = rawWord >> {lane, 3'b000};
    assign rawH     = rawWord >> {lane[LSB_W-1:1], 4'b0000};
    assign rawW     = rawWord >> {wordLane, 3'b000};

    always_comb begin
        extracted = XLEN'($signed(rawW[31:0]));
        case (loadOp)
            3'b001:  extracted = XLEN'($signed(rawB[7:0]));
            3'b101:  extracted = XLEN'(rawB[7:0]);
            3'b010:  extracted = XLEN'($signed(rawH[15:0]));
            3'b110:  extracted = XLEN'(rawH[15:0]);
            default: extracted = XLEN'($signed(rawW[31:0]));
        endcase
    end
`else
    logic unusedLoadOp;

    assign unusedLoadOp = ^loadOp;
    assign extracted    = rawWord;
`endif

    logic [XLEN-1:0] regWData;
    logic            dataReady;

    assign regWData      = resFromMem ? extracted : aluResult;
    assign dataReady     = ~resFromMem | readyGo;
    assign mem_to_wb_bus = {regW, regWAddr, regWData, pc};
    assign mem_to_id_bus = {memValid_q, regW, regWAddr, dataReady, regWData};

endmodule
